fp5_norm_round_pack: RTL and testbench
======================================

Name: fp5_norm_round_pack

Overview:
- Consumer end of the MAC5 multiplier's stage-2 pipeline register.
- Takes the registered raw product fields (3-bit significand product, sticky bit, 3-bit biased exponent, sign, special-value flags), normalizes and rounds them to nearest-even, and packs a 5-bit float {sign, exp[2:0], man}.
- Two-stage pipeline with a valid/ready handshake and a saturating overflow event counter, feeding the accumulator stage.

Parameters:
CNT_W, 8, width of the overflow event counter.

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  input fields valid
in_ready  out  1  stage can accept this cycle
in_mxy  in  3  significand product; [2]=overflow bit (product>=2), [1]=leading one when [2]=0
in_sr  in  1  sticky/round bit from multiplier (OR of discarded product bits)
in_ex  in  3  biased result exponent before normalization
in_sign  in  1  result sign
in_zero  in  1  result is zero (operand was zero)
in_inf  in  1  result is infinity (operand was inf)
out_valid  out  1  packed result valid
out_ready  in  1  downstream accepts
out_fp  out  5  {sign, exp[2:0], man}
out_ovf  out  1  this result overflowed (qualified by out_valid)
ovf_cnt  out  CNT_W  saturating count of overflowed results
cnt_clr  in  1  synchronous clear of ovf_cnt

Behaviour:
- Reset: out_valid=0, out_fp=0, out_ovf=0, ovf_cnt=0, both stage-valid bits 0. in_ready=1 in the first cycle after reset.
- Handshake:
  - Transfer in when in_valid & in_ready; out when out_valid & out_ready.
  - Stage k advances when it is empty or the next stage advances this cycle. in_ready = !s1_valid | s2_advance (combinational from out_ready).
  - Latency is 2 cycles from the accept edge to out_valid with no stall. Throughput is 1 per cycle.
  - out_fp and out_ovf stay stable while out_valid & !out_ready.
  - No result is lost or reordered.
- Stage 1 (normalize), internal exponent is 5-bit unsigned:
  - in_mxy[2]=1: e=in_ex+1, m=mxy[1], g=mxy[0], st=in_sr.
  - in_mxy[2]=0: e=in_ex, m=mxy[0], g=in_sr, st=0.
  - Registered along with sign and flags.
- Stage 2 (round/pack):
  - Round up iff g & (st | m), i.e. round-to-nearest, ties-to-even.
  - Rounding m=1 up gives m=0, e=e+1.
  - Overflow iff final e>=7 and neither flag is set. On overflow: out_fp={sign,3'b111,1'b0} (inf) and out_ovf=1.
- Specials, which override the arithmetic:
  - in_zero & in_inf gives NaN 5'b01111.
  - in_inf alone gives {sign,111,0}.
  - in_zero alone gives {sign,000,0}.
  - out_ovf=0 for all specials.
- Counter:
  - ovf_cnt increments by 1 on each overflowed result at its output transfer (out_valid & out_ready & out_ovf).
  - Saturates at 2^CNT_W-1.
  - cnt_clr has priority over increment in the same cycle.
- Reset mid-operation drops all in-flight data. The counter clears.
- in_mxy=0 without in_zero is treated as a normal value (m=0, no leading-one check). The producer guarantees this does not occur.

Optional Feature:
FP5_SATURATE_EN
- Defined: an overflowing result packs to max finite {sign,110,1}. out_ovf and ovf_cnt behave as above.
- Undefined: an overflowing result packs to inf {sign,111,0}.
- Explicit in_inf is unaffected in both cases.

Test Plan:
- mxy=011, sr=0, ex=3, sign=0, out_ready=1 -> out_fp=00111 exactly 2 cycles after accept, out_ovf=0.
- mxy=101, sr=1, ex=2, sign=1 -> shift and round up -> out_fp=10111.
- Tie: mxy=010, sr=1, ex=4 -> stays even -> out_fp=01000. Also mxy=011, sr=1, ex=4 -> carries -> 01010.
- Overflow: mxy=011, sr=1, ex=6 -> out_fp=01110 (01101 with FP5_SATURATE_EN), out_ovf=1, ovf_cnt 0->1. Then 300 overflows with CNT_W=8 -> ovf_cnt=255. Assert cnt_clr on an overflow transfer cycle -> ovf_cnt=0.
- Backpressure: out_ready=0, push 3 back-to-back -> in_ready drops after 2 accepted. Raise out_ready -> all 3 emerge in order, out_fp held stable during the stall.
- Specials, then reset: in_zero=1,sign=1 -> 10000. in_inf=1 -> x1110. Both set -> 01111. Assert rst with 2 items in flight -> out_valid=0 the next cycle, and those items never appear.

Source files
------------

// File: rtl/fp5_norm_round_pack_if.sv
// ---------------------------------------------------------------------------
// fp5_norm_round_pack_if
//   Handshake bundle between the MAC5 multiplier's stage-2 register (producer)
//   and the normalize/round/pack block, plus the packed-result side that feeds
//   the accumulator.
//
//   Producer -> block : in_valid, in_mxy[2:0], in_sr, in_ex[2:0], in_sign,
//                       in_zero, in_inf
//   Block -> producer : in_ready
//   Block -> consumer : out_valid, out_fp[4:0], out_ovf
//   Consumer -> block : out_ready
//
//   master : the environment side (drives fields and out_ready)
//   slave  : the fp5_norm_round_pack side
// ---------------------------------------------------------------------------
interface fp5_norm_round_pack_if;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_mxy;
    logic       in_sr;
    logic [2:0] in_ex;
    logic       in_sign;
    logic       in_zero;
    logic       in_inf;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] out_fp;
    logic       out_ovf;

    modport master (
        output in_valid, in_mxy, in_sr, in_ex, in_sign, in_zero, in_inf,
        output out_ready,
        input  in_ready, out_valid, out_fp, out_ovf
    );

    modport slave (
        input  in_valid, in_mxy, in_sr, in_ex, in_sign, in_zero, in_inf,
        input  out_ready,
        output in_ready, out_valid, out_fp, out_ovf
    );
endinterface

// File: rtl/fp5_norm_round_pack.sv
// ---------------------------------------------------------------------------
// fp5_norm_round_pack
//   Two-stage pipeline that turns the multiplier's raw product fields into a
//   packed 5-bit float {sign, exp[2:0], man}.
//     stage 1 : normalize (shift out the product overflow bit, bump exponent)
//     stage 2 : round-to-nearest-even, overflow detect, special values, pack
//   Valid/ready handshake on both sides; a full pipeline accepts one item per
//   cycle and holds its output stable under backpressure.
//
//   Ports
//     clk, rst      : clock, synchronous active-high reset
//     bus (slave)   : input fields + in_ready, out_valid/out_fp/out_ovf + out_ready
//     cnt_clr       : synchronous clear of ovf_cnt (wins over increment)
//     ovf_cnt       : saturating count of overflowed results at output transfer
//
//   Build option
//     FP5_SATURATE_EN : when defined an overflowing result packs to the
//                       largest finite value {sign,110,1} instead of infinity.
//                       Explicit infinity inputs still pack to {sign,111,0}.
// ---------------------------------------------------------------------------
module fp5_norm_round_pack #(
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    fp5_norm_round_pack_if.slave bus,
    input  logic                 cnt_clr,
    output logic [CNT_W-1:0]     ovf_cnt
);

    // Normalized payload carried between the stages. The exponent is widened
    // to 5 bits so the +1 from normalization and the +1 from rounding carry
    // can never wrap before the overflow compare.
    typedef struct packed {
        logic [4:0] e;
        logic       m;
        logic       g;
        logic       st;
        logic       sign;
        logic       zero;
        logic       inf;
    } s1_t;

    logic             s1_valid_q, s1_valid_d;
    s1_t              s1_q, s1_d, nrm;
    logic             s2_valid_q, s2_valid_d;
    logic [4:0]       out_fp_q, out_fp_d;
    logic             out_ovf_q, out_ovf_d;
    logic [CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;

    logic             s1_adv, s2_adv;
    logic             rnd;
    logic             m_r;
    logic [4:0]       e_r;
    logic             ovf;
    logic [4:0]       fp;

    // A stage advances when empty or when the stage after it drains this cycle.
    assign s2_adv       = !s2_valid_q | bus.out_ready;
    assign s1_adv       = !s1_valid_q | s2_adv;
    assign bus.in_ready = s1_adv;

    assign bus.out_valid = s2_valid_q;
    assign bus.out_fp    = out_fp_q;
    assign bus.out_ovf   = out_ovf_q;
    assign ovf_cnt       = ovf_cnt_q;

    // ---------------- stage 1: normalize ----------------
    always_comb begin
        nrm      = '0;
        nrm.sign = bus.in_sign;
        nrm.zero = bus.in_zero;
        nrm.inf  = bus.in_inf;
        if (bus.in_mxy[2]) begin
            // product >= 2: shift right one place, sticky collects sr
            nrm.e  = {2'b00, bus.in_ex} + 5'd1;
            nrm.m  = bus.in_mxy[1];
            nrm.g  = bus.in_mxy[0];
            nrm.st = bus.in_sr;
        end else begin
            // leading one already at [1]; sr becomes the guard bit
            nrm.e  = {2'b00, bus.in_ex};
            nrm.m  = bus.in_mxy[0];
            nrm.g  = bus.in_sr;
            nrm.st = 1'b0;
        end

        s1_valid_d = s1_valid_q;
        s1_d       = s1_q;
        if (s1_adv) begin
            s1_valid_d = bus.in_valid;
            if (bus.in_valid) s1_d = nrm;
        end
    end

    // ---------------- stage 2: round and pack ----------------
    always_comb begin
        // nearest-even: round up above half, or at exactly half when m is odd
        rnd = s1_q.g & (s1_q.st | s1_q.m);
        m_r = s1_q.m ^ rnd;
        e_r = s1_q.e + {4'b0000, rnd & s1_q.m};
        ovf = (e_r >= 5'd7) & !s1_q.zero & !s1_q.inf;

        if (s1_q.zero & s1_q.inf) begin
            fp = 5'b01111;                           // 0 * inf -> NaN
        end else if (s1_q.inf) begin
            fp = {s1_q.sign, 3'b111, 1'b0};
        end else if (s1_q.zero) begin
            fp = {s1_q.sign, 3'b000, 1'b0};
        end else if (ovf) begin
`ifdef FP5_SATURATE_EN
            fp = {s1_q.sign, 3'b110, 1'b1};
`else
            fp = {s1_q.sign, 3'b111, 1'b0};
`endif
        end else begin
            fp = {s1_q.sign, e_r[2:0], m_r};
        end

        s2_valid_d = s2_valid_q;
        out_fp_d   = out_fp_q;
        out_ovf_d  = out_ovf_q;
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_fp_d  = fp;
                out_ovf_d = ovf;
            end
        end
    end

    // ---------------- overflow event counter ----------------
    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        if (cnt_clr) begin
            ovf_cnt_d = '0;
        end else if (s2_valid_q && bus.out_ready && out_ovf_q && (ovf_cnt_q != '1)) begin
            ovf_cnt_d = ovf_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_q       <= '0;
            s2_valid_q <= 1'b0;
            out_fp_q   <= '0;
            out_ovf_q  <= 1'b0;
            ovf_cnt_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_q       <= s1_d;
            s2_valid_q <= s2_valid_d;
            out_fp_q   <= out_fp_d;
            out_ovf_q  <= out_ovf_d;
            ovf_cnt_q  <= ovf_cnt_d;
        end
    end

endmodule

// File: tb/tb_fp5_norm_round_pack.sv
module tb_fp5_norm_round_pack;
    localparam int CNT_W = 8;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cnt_clr = 1'b0;
    logic [CNT_W-1:0] ovf_cnt;

    fp5_norm_round_pack_if bus();

    fp5_norm_round_pack #(.CNT_W(CNT_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .cnt_clr (cnt_clr),
        .ovf_cnt (ovf_cnt)
    );

    always #5 clk = ~clk;

    int tests  = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: value = 1.m x 2^e with a remainder measured in quarter-LSBs
    // (2 means exactly half). Returns {ovf, fp}.
    function automatic logic [5:0] model(input logic [2:0] mxy, input logic sr,
                                         input logic [2:0] ex, input logic s,
                                         input logic z, input logic i);
        int e, keep, rem;
        logic [2:0] ef;
        if (z && i) return 6'b001111;
        if (i)      return {1'b0, s, 3'b111, 1'b0};
        if (z)      return {1'b0, s, 4'b0000};
        if (mxy[2]) begin
            e = int'(ex) + 1; keep = int'(mxy[1]); rem = int'(mxy[0]) * 2 + int'(sr);
        end else begin
            e = int'(ex);     keep = int'(mxy[0]); rem = int'(sr) * 2;
        end
        if (rem > 2 || (rem == 2 && keep == 1)) keep++;
        if (keep == 2) begin keep = 0; e++; end
        if (e >= 7) begin
`ifdef FP5_SATURATE_EN
            return {1'b1, s, 3'b110, 1'b1};
`else
            return {1'b1, s, 3'b111, 1'b0};
`endif
        end
        ef = e[2:0];
        return {1'b0, s, ef, keep[0]};
    endfunction

    // ---------------- scoreboard / compare process ----------------
    logic [5:0] q[$];
    int         exp_cnt = 0;
    bit         held = 0;
    logic [5:0] hold_v;

    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            exp_cnt = 0;
            held    = 0;
        end else begin
            chk("ovf_cnt", 32'(ovf_cnt), 32'(exp_cnt));
            if (held) begin
                chk("hold_valid", 32'(bus.out_valid), 32'd1);
                chk("hold_data", {26'd0, bus.out_ovf, bus.out_fp}, {26'd0, hold_v});
            end
            held = 0;
            if (bus.out_valid) begin
                if (q.size() == 0) begin
                    chk("spurious_out", 32'(bus.out_valid), 32'd0);
                end else begin
                    chk("out_data", {26'd0, bus.out_ovf, bus.out_fp}, {26'd0, q[0]});
                    if (bus.out_ready) begin
                        if (!cnt_clr && q[0][5] && exp_cnt < CMAX) exp_cnt++;
                        void'(q.pop_front());
                    end else begin
                        held   = 1;
                        hold_v = {bus.out_ovf, bus.out_fp};
                    end
                end
            end
            if (cnt_clr) exp_cnt = 0;
            if (bus.in_valid && bus.in_ready)
                q.push_back(model(bus.in_mxy, bus.in_sr, bus.in_ex, bus.in_sign,
                                  bus.in_zero, bus.in_inf));
        end
    end

    // ---------------- driver helpers ----------------
    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic push(input logic [2:0] mxy, input logic sr, input logic [2:0] ex,
                        input logic s, input logic z, input logic i);
        bit acc = 0;
        bus.in_valid = 1; bus.in_mxy = mxy; bus.in_sr = sr; bus.in_ex = ex;
        bus.in_sign = s; bus.in_zero = z; bus.in_inf = i;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk); acc = bus.in_ready;
            @(posedge clk); #1;
            if (acc) break;
        end
        if (!acc) begin
            tests++; errors++;
            $display("FAIL push_timeout: in_ready stayed 0");
        end
        bus.in_valid = 0;
    endtask

    task automatic wait_out();
        bit ok = 0;
        for (int k = 0; k < 20; k++) begin
            if (bus.out_valid) begin ok = 1; break; end
            cyc();
        end
        if (!ok) begin
            tests++; errors++;
            $display("FAIL out_timeout: out_valid stayed 0");
        end
    endtask

    task automatic expect_out(input string nm, input logic [4:0] fp, input logic ov);
        wait_out();
        chk({nm, "_fp"},  32'(bus.out_fp),  32'(fp));
        chk({nm, "_ovf"}, 32'(bus.out_ovf), 32'(ov));
    endtask

    task automatic do_reset();
        rst = 1; cyc(); cyc(); rst = 0;
    endtask

`ifdef FP5_SATURATE_EN
    localparam logic [4:0] OVF_POS = 5'b01101;
`else
    localparam logic [4:0] OVF_POS = 5'b01110;
`endif

    initial begin
        bus.in_valid = 0; bus.in_mxy = 0; bus.in_sr = 0; bus.in_ex = 0;
        bus.in_sign = 0; bus.in_zero = 0; bus.in_inf = 0; bus.out_ready = 1;
        do_reset();

        // reset state
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_fp",    32'(bus.out_fp),    32'd0);
        chk("rst_ovf",   32'(bus.out_ovf),   32'd0);
        chk("rst_cnt",   32'(ovf_cnt),       32'd0);
        chk("rst_ready", 32'(bus.in_ready),  32'd1);

        // latency: visible in the second cycle after the accept cycle
        push(3'b011, 0, 3'd3, 0, 0, 0);
        chk("lat_early", 32'(bus.out_valid), 32'd0);
        cyc();
        chk("lat_valid", 32'(bus.out_valid), 32'd1);
        chk("lat_fp",    32'(bus.out_fp),    32'b00111);
        chk("lat_ovf",   32'(bus.out_ovf),   32'd0);
        cyc();

        push(3'b101, 1, 3'd2, 1, 0, 0); expect_out("shift_rnd", 5'b10111, 0); cyc();
        push(3'b010, 1, 3'd4, 0, 0, 0); expect_out("tie_even",  5'b01000, 0); cyc();
        push(3'b011, 1, 3'd4, 0, 0, 0); expect_out("tie_carry", 5'b01010, 0); cyc();

        // overflow and counter
        push(3'b011, 1, 3'd6, 0, 0, 0); expect_out("ovf", OVF_POS, 1); cyc();
        chk("cnt_one", 32'(ovf_cnt), 32'd1);
        bus.in_valid = 1; bus.in_mxy = 3'b011; bus.in_sr = 1; bus.in_ex = 3'd6;
        repeat (300) cyc();
        bus.in_valid = 0;
        repeat (4) cyc();
        chk("cnt_sat", 32'(ovf_cnt), 32'(CMAX));
        push(3'b011, 1, 3'd6, 0, 0, 0); wait_out();
        cnt_clr = 1; cyc(); cnt_clr = 0;
        chk("cnt_clr", 32'(ovf_cnt), 32'd0);
        cyc();

        // backpressure
        bus.out_ready = 0;
        push(3'b011, 0, 3'd3, 0, 0, 0);
        push(3'b101, 1, 3'd2, 1, 0, 0);
        bus.in_valid = 1; bus.in_mxy = 3'b010; bus.in_sr = 1; bus.in_ex = 3'd4;
        bus.in_sign = 0;
        chk("bp_ready_low", 32'(bus.in_ready), 32'd0);
        chk("bp_head",      32'(bus.out_fp),   32'b00111);
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("bp_stable", 32'(bus.out_fp),   32'b00111);
            chk("bp_ready",  32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1;
        cyc(); bus.in_valid = 0;
        chk("bp_second", 32'(bus.out_fp), 32'b10111);
        cyc();
        chk("bp_third",  32'(bus.out_fp), 32'b01000);
        repeat (3) cyc();

        // specials
        push(3'b110, 1, 3'd7, 1, 1, 0); expect_out("zero", 5'b10000, 0); cyc();
        push(3'b110, 1, 3'd7, 0, 0, 1); expect_out("inf",  5'b01110, 0); cyc();
        push(3'b010, 0, 3'd1, 1, 1, 1); expect_out("nan",  5'b01111, 0); cyc();

        // reset with two in flight
        bus.out_ready = 0;
        push(3'b011, 0, 3'd1, 0, 0, 0);
        push(3'b010, 0, 3'd2, 1, 0, 0);
        rst = 1; cyc(); rst = 0;
        chk("rst_flight_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_flight_ready", 32'(bus.in_ready),  32'd1);
        bus.out_ready = 1;
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("rst_dropped", 32'(bus.out_valid), 32'd0);
        end

        // random traffic against the scoreboard
        for (int k = 0; k < 600; k++) begin
            bus.in_valid  = ($urandom_range(0, 9) < 7);
            bus.in_mxy    = 3'($urandom_range(2, 7));
            bus.in_sr     = 1'($urandom_range(0, 1));
            bus.in_ex     = 3'($urandom_range(0, 7));
            bus.in_sign   = 1'($urandom_range(0, 1));
            bus.in_zero   = ($urandom_range(0, 15) == 0);
            bus.in_inf    = ($urandom_range(0, 15) == 0);
            bus.out_ready = ($urandom_range(0, 9) < 7);
            cnt_clr       = ($urandom_range(0, 49) == 0);
            cyc();
        end
        bus.in_valid = 0; bus.out_ready = 1; cnt_clr = 0;
        repeat (5) cyc();
        chk("drain_empty", 32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        errors++;
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule
